pipe_stage_reg: RTL and testbench

- Parametrised, elastic inter-stage pipeline register. It is the successor to the fixed ID/EX, EX/MEM and MEM/WB latch stages.
- Carries a control field and a data field with a valid/ready handshake and a 2-entry skid buffer, so that full throughput survives a registered ready.
- Adds synchronous flush (bubble insertion) and a saturating stall-cycle counter.
- One instance sits between each pair of pipeline stages.

---
 rtl/pipe_stage_reg.sv | 121 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage pipeline register: main + skid entry, flush, saturating stall counter.
// Latency: one cycle from in_fire to out_valid_o; sustains one entry per cycle.
// Backpressure: in_ready_o = ~skid_valid (registered); the skid entry absorbs one beat after ready drops.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 101,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // State bits are {main_valid, skid_valid}; 2'b01 cannot be reached.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t              state;
  logic                main_valid;
  logic                skid_valid;
  logic [CTRL_W-1:0]   main_ctrl;
  logic [DATA_W-1:0]   main_data;
  logic [CTRL_W-1:0]   skid_ctrl;
  logic [DATA_W-1:0]   skid_data;
  logic [CNT_W-1:0]    stall_cnt;

  logic                in_fire;
  logic                out_fire;
  logic                load_main;
  logic                load_skid;
  logic                promote_skid;

  assign main_valid  = state[1];
  assign skid_valid  = state[0];

  assign in_ready_o  = ~skid_valid;
  assign out_valid_o = main_valid;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = main_valid & out_ready_i;

  // New entry goes straight to main when main is empty or draining this cycle,
  // otherwise it parks in the skid slot. In FULL, in_fire is impossible.
  assign load_main    = in_fire & (~main_valid | out_fire);
  assign load_skid    = in_fire & main_valid & ~out_fire;
  assign promote_skid = skid_valid & out_fire;

  // Bubbles present a zero control field; data is left as-is.
  assign out_ctrl_o  = main_valid ? main_ctrl : '0;
  assign out_data_o  = main_data;
  assign stall_cnt_o = stall_cnt;

  // Occupancy FSM; flush empties the stage ahead of any handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else if (flush_i) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_fire) state <= ONE;
        ONE: begin
          if (in_fire && !out_fire)      state <= FULL;
          else if (!in_fire && out_fire) state <= EMPTY;
        end
        FULL:    if (out_fire) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  // Payload registers; copied verbatim, untouched by a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (!flush_i) begin
      if (load_main) begin
        main_ctrl <= in_ctrl_i;
        main_data <= in_data_i;
      end else if (promote_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl_i;
        skid_data <= in_data_i;
      end
    end
  end

  // Count cycles where downstream refuses a valid entry; sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready_i && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  a_no_illegal_state: assert property (@(posedge clk) disable iff (rst)
    !(!main_valid && skid_valid));

  a_hold_under_backpressure: assert property (@(posedge clk) disable iff (rst)
    (out_valid_o && !out_ready_i && !flush_i) |=>
      (out_valid_o && $stable(out_data_o) && $stable(out_ctrl_o)));

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_ctrl;
  logic [100:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_ctrl;
  logic [100:0] out_data;
  logic [3:0]   stall_cnt;

  int vec;
  int err;

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(101), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_ctrl_i   (in_ctrl),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_ctrl_o  (out_ctrl),
    .out_data_o  (out_data),
    .stall_cnt_o (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    step(); step();
    vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    vec++; if (out_ctrl !== 8'h00) begin err++; $display("FAIL reset_ctrl: got %h want 00", out_ctrl); end
    vec++; if (out_data !== 101'h0) begin err++; $display("FAIL reset_data: got %h want 0", out_data); end
    vec++; if (stall_cnt !== 4'd0) begin err++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    step();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_data = 101'(i); in_ctrl = 8'(i);
      step();
      vec++; if (out_valid !== 1'b1) begin err++; $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid); end
      vec++; if (out_data !== 101'(i)) begin err++; $display("FAIL stream_data[%0d]: got %0d want %0d", i, out_data, i); end
      vec++; if (out_ctrl !== 8'(i)) begin err++; $display("FAIL stream_ctrl[%0d]: got %h want %h", i, out_ctrl, 8'(i)); end
      vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready); end
      vec++; if (stall_cnt !== 4'd0) begin err++; $display("FAIL stream_cnt[%0d]: got %0d want 0", i, stall_cnt); end
    end
    in_valid = 1'b0;
    step();
    vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL stream_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 101'h11; in_ctrl = 8'h11;
    step();
    vec++; if (out_data !== 101'h11) begin err++; $display("FAIL bp_a_data: got %h want 11", out_data); end
    vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL bp_one_ready: got %b want 1", in_ready); end
    in_data = 101'h22; in_ctrl = 8'h22;
    step();
    in_valid = 1'b0;
    vec++; if (in_ready !== 1'b0) begin err++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
    vec++; if (out_data !== 101'h11) begin err++; $display("FAIL bp_hold1: got %h want 11", out_data); end
    vec++; if (stall_cnt !== 4'd1) begin err++; $display("FAIL bp_cnt1: got %0d want 1", stall_cnt); end
    step(); step();
    vec++; if (out_data !== 101'h11) begin err++; $display("FAIL bp_hold3: got %h want 11", out_data); end
    vec++; if (out_ctrl !== 8'h11) begin err++; $display("FAIL bp_ctrl3: got %h want 11", out_ctrl); end
    vec++; if (stall_cnt !== 4'd3) begin err++; $display("FAIL bp_cnt3: got %0d want 3", stall_cnt); end
    vec++; if (in_ready !== 1'b0) begin err++; $display("FAIL bp_ready3: got %b want 0", in_ready); end
    out_ready = 1'b1;
    step();
    vec++; if (out_data !== 101'h22) begin err++; $display("FAIL bp_b_data: got %h want 22", out_data); end
    vec++; if (out_valid !== 1'b1) begin err++; $display("FAIL bp_b_valid: got %b want 1", out_valid); end
    vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL bp_ready_back: got %b want 1", in_ready); end
    step();
    vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL bp_empty: got %b want 0", out_valid); end
    vec++; if (stall_cnt !== 4'd3) begin err++; $display("FAIL bp_cnt_end: got %0d want 3", stall_cnt); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 101'h33; in_ctrl = 8'h33;
    step();
    in_data = 101'h44; in_ctrl = 8'h44;
    step();
    vec++; if (in_ready !== 1'b0) begin err++; $display("FAIL flush_pre_full: got %b want 0", in_ready); end
    flush = 1'b1; in_data = 101'hCC; in_ctrl = 8'hFF;
    step();
    flush = 1'b0; in_valid = 1'b0;
    vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    vec++; if (out_ctrl !== 8'h00) begin err++; $display("FAIL flush_ctrl: got %h want 00", out_ctrl); end
    vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL flush_ready: got %b want 1", in_ready); end
    vec++; if (out_data !== 101'h33) begin err++; $display("FAIL flush_data_kept: got %h want 33", out_data); end
    vec++; if (stall_cnt !== 4'd5) begin err++; $display("FAIL flush_cnt: got %0d want 5", stall_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL flush_no_c[%0d]: got %b want 0", i, out_valid); end
      vec++; if (out_data !== 101'h33) begin err++; $display("FAIL flush_no_c_data[%0d]: got %h want 33", i, out_data); end
    end
  endtask

  task automatic test_bubble();
    out_ready = 1'b1;
    in_valid = 1'b1; in_ctrl = 8'hA5; in_data = 101'h5A5A;
    step();
    in_valid = 1'b0;
    vec++; if (out_ctrl !== 8'hA5) begin err++; $display("FAIL bubble_live_ctrl: got %h want a5", out_ctrl); end
    step();
    vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL bubble_valid: got %b want 0", out_valid); end
    vec++; if (out_ctrl !== 8'h00) begin err++; $display("FAIL bubble_ctrl: got %h want 00", out_ctrl); end
    vec++; if (out_data !== 101'h5A5A) begin err++; $display("FAIL bubble_data: got %h want 5a5a", out_data); end
  endtask

  task automatic test_counter_sat();
    #3 rst = 1'b1;
    #1;
    vec++; if (stall_cnt !== 4'd0) begin err++; $display("FAIL sat_pre_clear: got %0d want 0", stall_cnt); end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'h5E; in_data = 101'h777;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 14; i++) step();
    vec++; if (stall_cnt !== 4'd14) begin err++; $display("FAIL sat_14: got %0d want 14", stall_cnt); end
    step();
    vec++; if (stall_cnt !== 4'd15) begin err++; $display("FAIL sat_15: got %0d want 15", stall_cnt); end
    for (int i = 0; i < 5; i++) step();
    vec++; if (stall_cnt !== 4'd15) begin err++; $display("FAIL sat_stay: got %0d want 15", stall_cnt); end
    vec++; if (out_data !== 101'h777) begin err++; $display("FAIL sat_data: got %h want 777", out_data); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL sat_flush_valid: got %b want 0", out_valid); end
    vec++; if (stall_cnt !== 4'd15) begin err++; $display("FAIL sat_flush_keep: got %0d want 15", stall_cnt); end
    #3 rst = 1'b1;
    #1;
    vec++; if (stall_cnt !== 4'd0) begin err++; $display("FAIL sat_rst_clear: got %0d want 0", stall_cnt); end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_async_reset();
    step();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'h01; in_data = 101'hD1;
    step();
    in_ctrl = 8'h02; in_data = 101'hD2;
    step();
    in_valid = 1'b0;
    vec++; if (in_ready !== 1'b0) begin err++; $display("FAIL ar_full: got %b want 0", in_ready); end
    #3 rst = 1'b1;
    #1;
    vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL ar_valid: got %b want 0", out_valid); end
    vec++; if (out_ctrl !== 8'h00) begin err++; $display("FAIL ar_ctrl: got %h want 00", out_ctrl); end
    vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL ar_ready: got %b want 1", in_ready); end
    vec++; if (out_data !== 101'h0) begin err++; $display("FAIL ar_data: got %h want 0", out_data); end
    vec++; if (stall_cnt !== 4'd0) begin err++; $display("FAIL ar_cnt: got %0d want 0", stall_cnt); end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'h3C; in_data = 101'hDD; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    vec++; if (out_valid !== 1'b1) begin err++; $display("FAIL ar_d_valid: got %b want 1", out_valid); end
    vec++; if (out_data !== 101'hDD) begin err++; $display("FAIL ar_d_data: got %h want dd", out_data); end
    vec++; if (out_ctrl !== 8'h3C) begin err++; $display("FAIL ar_d_ctrl: got %h want 3c", out_ctrl); end
    step();
    vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL ar_d_drain: got %b want 0", out_valid); end
  endtask

  initial begin
    vec = 0;
    err = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_bubble();
    test_counter_sat();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
